i2s_frame_fifo: RTL
===================

Name: i2s_frame_fifo

Overview:
- Downstream stage of the I2S controller.
- Captures each single-cycle stereo frame strobe (data_valid with data_out_0/data_out_1) into a small synchronous FIFO.
- Re-presents frames on a valid/ready stream so slower consumers (DSP, UART bridge, DMA) can absorb them without losing data.
- The I2S side cannot be back-pressured, so overflow is detected, flagged and counted.

Parameters:
- bits_per_word, 32: width of each channel word; must match the upstream I2S controller.
- depth_log2, 4: FIFO depth is 2**depth_log2 frames; legal range 1..8.
- ovf_count_width, 16: width of the saturating overflow counter.

Ports:
- clock  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  one-cycle frame strobe from the I2S controller.
- in_data_0  input  bits_per_word  lrck=0 channel word, sampled when in_valid=1.
- in_data_1  input  bits_per_word  lrck=1 channel word, sampled when in_valid=1.
- out_valid  output  1  a frame is presented on out_data_0/1.
- out_ready  input  1  consumer accepts the frame; a pop happens when out_valid && out_ready.
- out_data_0  output  bits_per_word  head-of-FIFO lrck=0 word.
- out_data_1  output  bits_per_word  head-of-FIFO lrck=1 word.
- level  output  depth_log2+1  number of frames currently stored, 0..2**depth_log2.
- overflow  output  1  sticky flag; set when a frame was dropped.
- overflow_count  output  ovf_count_width  saturating count of dropped/overwritten frames.
- clear_overflow  input  1  one-cycle pulse; clears overflow and overflow_count.

Behaviour:
- Reset (synchronous, any cycle including mid-operation):
  - wr_ptr = rd_ptr = 0, level = 0, out_valid = 0, overflow = 0, overflow_count = 0.
  - Stored frame contents are discarded.
  - out_data_0/1 = 0.
- Storage:
  - Register array of 2**depth_log2 entries, each {in_data_1, in_data_0}.
  - Pointers are depth_log2+1 bits wide; the extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2**(depth_log2+1).
- Derived state:
  - empty = (wr_ptr == rd_ptr).
  - full = (pointer low bits equal) and (MSBs differ).
- Output presentation:
  - First-word-fall-through; out_valid = !empty, registered state only, no combinational path from in_valid.
  - out_data_0/1 = mem[rd_ptr low bits].
- Latency:
  - A frame written in cycle N (FIFO empty) gives out_valid=1 with that frame in cycle N+1.
  - There is no same-cycle bypass.
- Pop: when out_valid && out_ready, rd_ptr increments next cycle.
- Stability: while out_valid=1 and out_ready=0, out_data_0/1 hold stable (except the drop-oldest case under the optional feature).
- Push acceptance:
  - push_ok = in_valid && (!full || pop).
  - When full, a push and a pop in the same cycle both proceed and level is unchanged.
- Level update: level increments on push only, decrements on pop only, and is unchanged on both or neither.
- Overflow event: in_valid && full && !pop.
  - Default: the incoming frame is dropped and the FIFO is unchanged.
  - overflow is set to 1.
  - overflow_count increments, saturating at all-ones.
- clear_overflow:
  - Sets overflow=0 and overflow_count=0 next cycle.
  - If an overflow event occurs in the same cycle, the event wins: overflow=1, overflow_count=1.
- out_ready while empty is ignored and has no effect.
- in_valid in consecutive cycles is legal; each cycle is a separate frame.

Optional Feature:
- Macro: I2S_FRAME_FIFO_DROP_OLDEST_EN.
- Defined:
  - On an overflow event, the oldest frame is discarded and the new frame is written: rd_ptr and wr_ptr both advance and level stays full.
  - overflow and overflow_count update as in the default.
  - out_data may change while out_valid=1 and out_ready=0, but only in that cycle.
- Undefined: drop-newest behaviour as described in Behaviour.

Test Plan:
- Reset then idle 10 cycles -> out_valid=0, level=0, overflow=0, overflow_count=0, out_data_0/1=0.
- Single push in_data_0=0x11111111, in_data_1=0x22222222 at cycle N, out_ready=0 -> cycle N+1: out_valid=1, outputs show those words, level=1. Hold 5 cycles -> data stable. Raise out_ready one cycle -> level=0, out_valid=0.
- Depth 16, push frames 0..15 with out_ready=0 -> level=16. Push frame 16 -> overflow=1, overflow_count=1, level=16. Drain 16 pops -> data order 0..15 (default build); the drop-oldest build yields 1..16.
- Full FIFO with push and pop in the same cycle -> level stays 16, popped frame 0, new frame appears last. overflow unchanged.
- overflow_count_width=4, 20 overflow events -> count saturates at 15. clear_overflow coincident with a new overflow event -> overflow=1, overflow_count=1. clear_overflow alone -> overflow=0, overflow_count=0.
- Reset asserted with level=7 and out_valid=1 -> next cycle level=0, out_valid=0, pointers 0. A subsequent push is output after 1 cycle with correct data.

Source files
------------

// File: rtl/i2s_frame_fifo.sv
// Frame FIFO between the I2S controller and a valid/ready consumer, with overflow flag and saturating counter.
// Optional macro I2S_FRAME_FIFO_DROP_OLDEST_EN: on overflow, overwrite the oldest frame instead of dropping the new one.
module i2s_frame_fifo #(
  parameter int bits_per_word   = 32,
  parameter int depth_log2      = 4,
  parameter int ovf_count_width = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [bits_per_word-1:0]   in_data_0,
  input  logic [bits_per_word-1:0]   in_data_1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [bits_per_word-1:0]   out_data_0,
  output logic [bits_per_word-1:0]   out_data_1,
  output logic [depth_log2:0]        level,
  output logic                       overflow,
  output logic [ovf_count_width-1:0] overflow_count,
  input  logic                       clear_overflow
);

  localparam int DEPTH = 1 << depth_log2;

  logic [2*bits_per_word-1:0] r_mem [DEPTH];
  logic [depth_log2:0]        r_wr_ptr;
  logic [depth_log2:0]        r_rd_ptr;
  logic                       r_overflow;
  logic [ovf_count_width-1:0] r_ovf_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ovf_event;
  logic w_write;
  logic w_rd_adv;
  logic w_count_max;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[depth_log2-1:0] == r_rd_ptr[depth_log2-1:0]) &&
                       (r_wr_ptr[depth_log2] != r_rd_ptr[depth_log2]);
  assign w_pop       = !w_empty && out_ready;
  assign w_push      = in_valid && (!w_full || w_pop);
  assign w_ovf_event = in_valid && w_full && !w_pop;
  assign w_count_max = &r_ovf_count;

`ifdef I2S_FRAME_FIFO_DROP_OLDEST_EN
  // When full, wr and rd low bits coincide, so writing overwrites the oldest slot.
  assign w_write  = w_push || w_ovf_event;
  assign w_rd_adv = w_pop || w_ovf_event;
`else
  assign w_write  = w_push;
  assign w_rd_adv = w_pop;
`endif

  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_wr_ptr[depth_log2-1:0]] <= {in_data_1, in_data_0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // An overflow in the same cycle as clear_overflow restarts the count at one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end else if (w_ovf_event) begin
      r_overflow <= 1'b1;
      if (clear_overflow) begin
        r_ovf_count <= ovf_count_width'(1);
      end else if (!w_count_max) begin
        r_ovf_count <= r_ovf_count + 1'b1;
      end
    end else if (clear_overflow) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end
  end

  // Unwritten storage is never exposed: data reads as zero while empty.
  assign {out_data_1, out_data_0} = w_empty ? '0 : r_mem[r_rd_ptr[depth_log2-1:0]];
  assign out_valid      = !w_empty;
  assign level          = r_wr_ptr - r_rd_ptr;
  assign overflow       = r_overflow;
  assign overflow_count = r_ovf_count;

endmodule
